// File: rtl/fire_writer_pkg.sv
// Shared types and sizing helpers for the conv-layer output feature-map writer.
package fire_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } wr_state_e;

  localparam int DEF_DSP_NO = 128;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_WOUT   = 32;

  function automatic int addr_w(input int dsp_no, input int wout);
    return $clog2(dsp_no * wout * wout);
  endfunction

  // Counter width that never collapses to zero bits for a count of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fire_ofm_addr_gen.sv
// Channel / pixel counters and channel-major RAM address for the OFM writer.
module fire_ofm_addr_gen
  import fire_writer_pkg::*;
#(
  parameter int DSP_NO = DEF_DSP_NO,
  parameter int WOUT   = DEF_WOUT,
  parameter int ADDR_W = addr_w(DEF_DSP_NO, DEF_WOUT),
  localparam int CH_W  = cnt_w(DSP_NO),
  localparam int PIX_W = cnt_w(WOUT * WOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              adv,
  output logic [CH_W-1:0]   ch,
  output logic [ADDR_W-1:0] addr,
  output logic              last_lane,
  output logic              last_pix
);

  localparam int NPIX = WOUT * WOUT;
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(NPIX);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(DSP_NO - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(NPIX - 1);

  logic [PIX_W-1:0]  pix_r;
  logic [ADDR_W-1:0] base_r;

  // Running channel base replaces ch*WOUT**2; it clears whenever the lane index wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch     <= '0;
      pix_r  <= '0;
      base_r <= '0;
    end else if (start) begin
      ch     <= '0;
      base_r <= '0;
    end else if (adv) begin
      if (last_lane) begin
        ch     <= '0;
        base_r <= '0;
        pix_r  <= last_pix ? '0 : (pix_r + PIX_W'(1));
      end else begin
        ch     <= ch + CH_W'(1);
        base_r <= base_r + STRIDE;
      end
    end
  end

  assign addr      = base_r + ADDR_W'(pix_r);
  assign last_lane = (ch == LAST_CH);
  assign last_pix  = (pix_r == LAST_PIX);

endmodule

// File: rtl/fire_ofm_writer.sv
// Serialises each DSP_NO-lane output vector into channel-major single-word RAM writes,
// with a one-deep skid buffer and a completion pulse after the final pixel.
module fire_ofm_writer
  import fire_writer_pkg::*;
#(
  parameter int DSP_NO  = DEF_DSP_NO,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int WOUT    = DEF_WOUT,
  localparam int ADDR_W = addr_w(DSP_NO, WOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_sample,
  input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              ram_feedback,
  output logic              busy,
  output logic              overflow
);

  localparam int CH_W = cnt_w(DSP_NO);

  wr_state_e state_r;
  wr_state_e state_nx_s;

  logic [WIDTH-1:0]  cur_r  [0:DSP_NO-1];
  logic [WIDTH-1:0]  pend_r [0:DSP_NO-1];
  logic              pend_valid_r;
  logic              final_r;

  logic [CH_W-1:0]   ch_s;
  logic [ADDR_W-1:0] addr_s;
  logic              last_lane_s;
  logic              last_pix_s;

  logic start_s;
  logic adv_s;
  logic load_cur_ofm_s;
  logic load_cur_pend_s;
  logic load_pend_s;
  logic clr_pend_s;
  logic set_ovf_s;
  logic final_s;

  fire_ofm_addr_gen #(
    .DSP_NO (DSP_NO),
    .WOUT   (WOUT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .adv       (adv_s),
    .ch        (ch_s),
    .addr      (addr_s),
    .last_lane (last_lane_s),
    .last_pix  (last_pix_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and buffer-control decode.
  always_comb begin
    state_nx_s      = state_r;
    start_s         = 1'b0;
    adv_s           = 1'b0;
    load_cur_ofm_s  = 1'b0;
    load_cur_pend_s = 1'b0;
    load_pend_s     = 1'b0;
    clr_pend_s      = 1'b0;
    set_ovf_s       = 1'b0;
    final_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (layer_sample) begin
          load_cur_ofm_s = 1'b1;
          start_s        = 1'b1;
          state_nx_s     = DRAIN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DRAIN: begin
        adv_s = 1'b1;
        if (last_lane_s) begin
          if (last_pix_s) begin
            // Anything arriving on the final lane of the final pixel is beyond the layer.
            final_s    = 1'b1;
            state_nx_s = DONE;
          end else if (pend_valid_r) begin
            load_cur_pend_s = 1'b1;
            if (layer_sample) begin
              load_pend_s = 1'b1;
            end else begin
              clr_pend_s = 1'b1;
            end
          end else if (layer_sample) begin
            load_cur_ofm_s = 1'b1;
          end else begin
            state_nx_s = IDLE;
          end
        end else if (layer_sample) begin
          if (pend_valid_r) begin
            set_ovf_s = 1'b1;
          end else begin
            load_pend_s = 1'b1;
          end
        end else begin
          state_nx_s = DRAIN;
        end
      end
      DONE: begin
        state_nx_s = DONE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Vector buffers and skid-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r        <= '{default: '0};
      pend_r       <= '{default: '0};
      pend_valid_r <= 1'b0;
    end else begin
      if (load_cur_ofm_s) begin
        cur_r <= ofm;
      end else if (load_cur_pend_s) begin
        cur_r <= pend_r;
      end
      if (load_pend_s) begin
        pend_r       <= ofm;
        pend_valid_r <= 1'b1;
      end else if (clr_pend_s) begin
        pend_valid_r <= 1'b0;
      end
    end
  end

  // Registered RAM port and status outputs; address and data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      final_r      <= 1'b0;
      ram_feedback <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      wr_en <= adv_s;
      if (adv_s) begin
        wr_addr <= addr_s;
        wr_data <= cur_r[ch_s];
      end
      final_r      <= final_s;
      ram_feedback <= final_r;
      busy         <= (state_nx_s == DRAIN);
      if (set_ovf_s) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fire_ofm_writer.sv
// Directed self-checking bench for fire_ofm_writer with DSP_NO=4, WIDTH=16, WOUT=2.
module tb_fire_ofm_writer;

  localparam int DSP_NO = 4;
  localparam int WIDTH  = 16;
  localparam int WOUT   = 2;
  localparam int NPIX   = WOUT * WOUT;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              layer_sample;
  logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              ram_feedback;
  logic              busy;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fb_cnt   = 0;
  int fb_cyc   = 0;

  int wq_addr [$];
  int wq_data [$];
  int wq_cyc  [$];
  int exp_addr [$];
  int exp_data [$];

  fire_ofm_writer #(
    .DSP_NO (DSP_NO),
    .WIDTH  (WIDTH),
    .WOUT   (WOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .layer_sample (layer_sample),
    .ofm          (ofm),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .ram_feedback (ram_feedback),
    .busy         (busy),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write / feedback monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(int'(wr_data));
      wq_cyc.push_back(cyc);
    end
    if (ram_feedback) begin
      fb_cnt <= fb_cnt + 1;
      fb_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    ofm[0] = a; ofm[1] = b; ofm[2] = c; ofm[3] = d;
    layer_sample = 1'b1;
    tick();
    layer_sample = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    tick();
  endtask

  // Expected channel-major addresses: lane*WOUT**2 + pix.
  task automatic exp_group(input int pix, input int a, input int b, input int c, input int d);
    exp_addr.push_back(0 * NPIX + pix); exp_data.push_back(a);
    exp_addr.push_back(1 * NPIX + pix); exp_data.push_back(b);
    exp_addr.push_back(2 * NPIX + pix); exp_data.push_back(c);
    exp_addr.push_back(3 * NPIX + pix); exp_data.push_back(d);
  endtask

  task automatic verify(input string tag, input int s, input bit contig);
    check_eq({tag, "_nwrites"}, wq_addr.size() - s, exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (s + i < wq_addr.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), wq_addr[s + i], exp_addr[i]);
        check_eq($sformatf("%s_data%0d", tag, i), wq_data[s + i], exp_data[i]);
        if (contig && i > 0) begin
          check_eq($sformatf("%s_gap%0d", tag, i), wq_cyc[s + i] - wq_cyc[s + i - 1], 1);
        end
      end
    end
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    int s;
    int cap;
    int fb0;
    rst = 1'b1;
    layer_sample = 1'b0;
    for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;
    idle(3);
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_feedback", ram_feedback, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();

    // Single vector drain, latency and hold.
    s = wq_addr.size();
    exp_group(0, 'h11, 'h22, 'h33, 'h44);
    pulse(16'h11, 16'h22, 16'h33, 16'h44);
    cap = cyc;
    check_eq("t1_busy", busy, 1);
    idle(6);
    check_eq("t1_idle_busy", busy, 0);
    check_eq("t1_latency", (wq_cyc.size() > s) ? wq_cyc[s] : 0, cap + 1);
    verify("t1", s, 1'b1);
    check_eq("t1_addr_hold", wr_addr, 12);
    check_eq("t1_data_hold", wr_data, 'h44);

    // Second vector into the skid buffer, no bubble.
    do_reset();
    s = wq_addr.size();
    exp_group(0, 'h11, 'h22, 'h33, 'h44);
    exp_group(1, 'hA, 'hB, 'hC, 'hD);
    pulse(16'h11, 16'h22, 16'h33, 16'h44);
    idle(1);
    pulse(16'hA, 16'hB, 16'hC, 16'hD);
    idle(10);
    verify("t2", s, 1'b1);
    check_eq("t2_overflow", overflow, 0);

    // Sample on the last lane with empty skid goes straight to cur.
    do_reset();
    s = wq_addr.size();
    exp_group(0, 'h1, 'h2, 'h3, 'h4);
    exp_group(1, 'h5, 'h6, 'h7, 'h8);
    pulse(16'h1, 16'h2, 16'h3, 16'h4);
    idle(3);
    pulse(16'h5, 16'h6, 16'h7, 16'h8);
    idle(10);
    verify("t2b", s, 1'b1);
    check_eq("t2b_overflow", overflow, 0);

    // Three samples in one drain window: third dropped, sticky overflow.
    do_reset();
    s = wq_addr.size();
    exp_group(0, 'h101, 'h102, 'h103, 'h104);
    exp_group(1, 'h201, 'h202, 'h203, 'h204);
    pulse(16'h101, 16'h102, 16'h103, 16'h104);
    pulse(16'h201, 16'h202, 16'h203, 16'h204);
    pulse(16'h301, 16'h302, 16'h303, 16'h304);
    check_eq("t3_overflow", overflow, 1);
    idle(10);
    verify("t3", s, 1'b1);
    idle(5);
    check_eq("t3_overflow_sticky", overflow, 1);

    // Skid full and new sample on the last lane: swap, no overflow.
    do_reset();
    s = wq_addr.size();
    exp_group(0, 'hA1, 'hA2, 'hA3, 'hA4);
    exp_group(1, 'hB1, 'hB2, 'hB3, 'hB4);
    exp_group(2, 'hC1, 'hC2, 'hC3, 'hC4);
    pulse(16'hA1, 16'hA2, 16'hA3, 16'hA4);
    pulse(16'hB1, 16'hB2, 16'hB3, 16'hB4);
    idle(2);
    pulse(16'hC1, 16'hC2, 16'hC3, 16'hC4);
    idle(16);
    verify("t3b", s, 1'b1);
    check_eq("t3b_overflow", overflow, 0);

    // Whole layer: every address once, one feedback pulse, then DONE ignores samples.
    do_reset();
    s = wq_addr.size();
    fb0 = fb_cnt;
    for (int p = 0; p < NPIX; p++) begin
      exp_group(p, 'h100 * p + 1, 'h100 * p + 2, 'h100 * p + 3, 'h100 * p + 4);
      pulse(16'(16'h100 * p + 1), 16'(16'h100 * p + 2), 16'(16'h100 * p + 3), 16'(16'h100 * p + 4));
      idle(7);
    end
    check_eq("t4_last_addr", (wq_addr.size() > 0) ? wq_addr[$] : 0, 15);
    check_eq("t4_fb_count", fb_cnt - fb0, 1);
    check_eq("t4_fb_cycle", fb_cyc, ((wq_cyc.size() > 0) ? wq_cyc[$] : 0) + 1);
    verify("t4", s, 1'b0);
    s = wq_addr.size();
    pulse(16'hEE, 16'hEE, 16'hEE, 16'hEE);
    idle(8);
    check_eq("t4_done_nwrites", wq_addr.size() - s, 0);
    check_eq("t4_done_overflow", overflow, 0);
    check_eq("t4_done_busy", busy, 0);
    check_eq("t4_done_fb_count", fb_cnt - fb0, 1);

    // Reset in the middle of a drain aborts it; next sample restarts at address 0.
    do_reset();
    s = wq_addr.size();
    pulse(16'h31, 16'h32, 16'h33, 16'h34);
    idle(2);
    rst = 1'b1;
    tick();
    check_eq("t5_rst_wr_en", wr_en, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_overflow", overflow, 0);
    rst = 1'b0;
    idle(3);
    check_eq("t5_abort_nwrites", wq_addr.size() - s, 2);
    s = wq_addr.size();
    exp_group(0, 'h41, 'h42, 'h43, 'h44);
    pulse(16'h41, 16'h42, 16'h43, 16'h44);
    idle(6);
    verify("t5", s, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
